perf_event_tracker: RTL and testbench
=====================================

// Module: perf_event_tracker
// PURPOSE
// - Upstream feeder of the performance counter block: conditions raw pipeline signals into
//   registered, one-cycle event pulses and owns perf_enable.
// - Run-control FSM opens the measurement window at start and closes it on program end
//   (ZERO_RUN consecutive all-zero retirements) or on a cycle watchdog.
// PARAMETERS
// - ZERO_RUN     10          consecutive retired 32'h0 instructions that mark program end
// - MAX_CYCLES   1_000_000   watchdog: RUN cycles before forced DONE (0 = disabled)
// PORTS
// - clk                 in   1   core clock
// - rst_n               in   1   asynchronous active-low reset
// - start               in   1   level/pulse; opens window from IDLE
// - wb_valid            in   1   valid instruction in WB this cycle
// - wb_instr            in   32  instruction word in WB
// - pc_stall            in   1   IF/ID hold from hazard unit
// - id_ex_flush         in   1   NOP injected into ID/EX
// - fwd_a_sel, fwd_b_sel in  2   forward mux selects (00 none, 01 EX/MEM, 10 MEM/WB)
// - load_use_hazard     in   1   RAW hazard detected by hazard unit
// - ex_valid            in   1   valid instruction in EX
// - ex_is_branch        in   1   conditional branch in EX
// - ex_is_jump          in   1   JAL/JALR in EX
// - ex_taken            in   1   branch/jump resolved taken
// - ex_redirect         in   1   PC redirect + flush (predict-not-taken miss)
// - perf_enable         out  1   measurement window open
// - instruction_retired out  1   non-zero instruction retired
// - stall, bubble       out  1   event pulses
// - forward_ex_to_ex    out  1   any operand select == 01
// - forward_mem_to_ex   out  1   any operand select == 10
// - raw_hazard_detected out  1   event pulse
// - branch_instruction, branch_taken, branch_mispredicted  out 1 each
// - program_done        out  1   sticky, FSM in DONE
// - timeout             out  1   sticky, DONE reached via watchdog
// BEHAVIOUR
// - Reset (async assert, sync deassert): FSM=IDLE, all outputs 0, zero_cnt=0, cyc_cnt=0.
// - All outputs registered: events sampled in cycle N appear in N+1 together with the
//   perf_enable value computed in N, so pulse and window stay aligned.
// - FSM: IDLE -> RUN when start=1. RUN -> DONE when zero_cnt reaches ZERO_RUN, or when
//   MAX_CYCLES!=0 and cyc_cnt==MAX_CYCLES-1 (timeout=1). DONE exits only via rst_n.
// - perf_enable = (state==RUN); the ZERO_RUN closing cycles stay inside the window;
//   downstream counter subtracts ZERO_RUN.
// - zero_cnt: wb_valid & wb_instr==0 -> +1 (saturating); wb_valid & nonzero -> 0;
//   wb_valid=0 -> hold. Cleared on IDLE->RUN.
// - instruction_retired = wb_valid & (wb_instr!=0); zero words never counted.
// - branch_instruction = ex_valid & (ex_is_branch|ex_is_jump); branch_taken additionally
//   needs ex_taken; branch_mispredicted = ex_valid & ex_redirect.
// - forward outputs: both operands forwarding in one cycle -> single pulse per kind;
//   select 11 treated as none.
// - Events outside RUN forced to 0. start in RUN/DONE ignored. Same-cycle timeout and
//   zero-run completion: DONE with timeout=1.
// - cyc_cnt 32-bit, counts RUN cycles only, saturates.
// STRUCTURE
// - perf_pkg: FWD_NONE/FWD_EX_MEM/FWD_MEM_WB encodings, run_state_t {IDLE,RUN,DONE}.
// - Sub-module perf_halt_detector: zero_cnt + cyc_cnt + FSM; top does event retiming.
// TESTING
// - Reset mid-RUN (rst_n low 1 cycle) -> all outputs 0 async, state IDLE, start required.
// - start, 5 nonzero retirements, 10 zero retirements -> 5 instruction_retired pulses,
//   perf_enable falls 1 cycle after 10th zero, program_done=1, timeout=0.
// - 9 zeros, 1 nonzero, 10 zeros -> DONE only after final 10th zero; 1 retired pulse.
// - fwd_a_sel=01, fwd_b_sel=10 same cycle -> both forward pulses 1 next cycle; 11 -> none.
// - ex_valid, ex_is_branch, ex_taken, ex_redirect -> branch_instruction, branch_taken,
//   branch_mispredicted next cycle; ex_valid=0 -> no pulses.
// - MAX_CYCLES=20, no zeros -> perf_enable high exactly 20 cycles, timeout=1; later events 0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and encodings for the performance event tracker.
// Covers the forward-select codes, the run-control states and the event bundle.
package perf_pkg;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_WB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } run_state_t;

    typedef struct packed {
        logic perf_enable;
        logic instruction_retired;
        logic stall;
        logic bubble;
        logic forward_ex_to_ex;
        logic forward_mem_to_ex;
        logic raw_hazard_detected;
        logic branch_instruction;
        logic branch_taken;
        logic branch_mispredicted;
    } perf_events_t;

    localparam perf_events_t EVENTS_IDLE = '{default: 1'b0};

    // Encoding 2'b11 never matches a kind, so it behaves as "no forward".
    function automatic logic fwd_hit(input logic [1:0] sel_a,
                                     input logic [1:0] sel_b,
                                     input logic [1:0] kind);
        return (sel_a == kind) || (sel_b == kind);
    endfunction

endpackage

// File: rtl/perf_halt_detector.sv
// Run-control for the measurement window: zero-retirement run counter,
// RUN-cycle watchdog and the IDLE/RUN/DONE state machine.
module perf_halt_detector
    import perf_pkg::*;
#(
    parameter int unsigned ZERO_RUN   = 10,
    parameter int unsigned MAX_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wb_valid,
    input  logic [31:0] wb_instr,
    output logic        run_active,
    output logic        program_done,
    output logic        timeout
);

    localparam int unsigned ZW = ($clog2(ZERO_RUN + 1) < 2) ? 2 : $clog2(ZERO_RUN + 1);
    localparam logic [ZW-1:0] ZERO_RUN_C = ZW'(ZERO_RUN);
    localparam logic [ZW-1:0] ZERO_ONE   = {{(ZW-1){1'b0}}, 1'b1};
    localparam logic [ZW-1:0] ZERO_CLR   = {ZW{1'b0}};
    localparam logic [31:0]   CYC_LAST   = MAX_CYCLES - 32'd1;
    localparam bit            WD_EN      = (MAX_CYCLES != 32'd0);

    run_state_t    state_q, state_d;
    logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
    logic [31:0]   cyc_cnt_q, cyc_cnt_d;
    logic          timeout_q, timeout_d;
    logic          program_done_q, program_done_d;
    logic          wd_hit_s;
    logic          zero_hit_s;

    // Next-state logic for the run FSM and its two counters.
    always_comb begin
        state_d    = state_q;
        zero_cnt_d = zero_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        timeout_d  = timeout_q;
        wd_hit_s   = 1'b0;
        zero_hit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    zero_cnt_d = ZERO_CLR;
                    cyc_cnt_d  = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (wb_valid) begin
                    if (wb_instr == 32'h0000_0000) begin
                        if (zero_cnt_q != ZERO_RUN_C) begin
                            zero_cnt_d = zero_cnt_q + ZERO_ONE;
                        end else begin
                            zero_cnt_d = zero_cnt_q;
                        end
                    end else begin
                        zero_cnt_d = ZERO_CLR;
                    end
                end else begin
                    zero_cnt_d = zero_cnt_q;
                end
                if (cyc_cnt_q != 32'hFFFF_FFFF) begin
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q;
                end
                wd_hit_s   = WD_EN & (cyc_cnt_q == CYC_LAST);
                zero_hit_s = (zero_cnt_d == ZERO_RUN_C);
                // Watchdog takes priority so a coincident zero-run still flags timeout.
                if (wd_hit_s) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if (zero_hit_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        program_done_d = (state_d == DONE);
    end

    // State, counter and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            zero_cnt_q     <= ZERO_CLR;
            cyc_cnt_q      <= 32'd0;
            timeout_q      <= 1'b0;
            program_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            zero_cnt_q     <= zero_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            timeout_q      <= timeout_d;
            program_done_q <= program_done_d;
        end
    end

    assign run_active   = (state_q == RUN);
    assign program_done = program_done_q;
    assign timeout      = timeout_q;

endmodule

// File: rtl/perf_event_tracker.sv
// Conditions raw pipeline signals into registered one-cycle event pulses,
// gated by the measurement window owned by the halt detector.
module perf_event_tracker
    import perf_pkg::*;
#(
    parameter int unsigned ZERO_RUN   = 10,
    parameter int unsigned MAX_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wb_valid,
    input  logic [31:0] wb_instr,
    input  logic        pc_stall,
    input  logic        id_ex_flush,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic        load_use_hazard,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic        ex_redirect,
    output logic        perf_enable,
    output logic        instruction_retired,
    output logic        stall,
    output logic        bubble,
    output logic        forward_ex_to_ex,
    output logic        forward_mem_to_ex,
    output logic        raw_hazard_detected,
    output logic        branch_instruction,
    output logic        branch_taken,
    output logic        branch_mispredicted,
    output logic        program_done,
    output logic        timeout
);

    perf_events_t ev_d, ev_q;
    logic         run_s;

    perf_halt_detector #(
        .ZERO_RUN   (ZERO_RUN),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_halt (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .wb_valid     (wb_valid),
        .wb_instr     (wb_instr),
        .run_active   (run_s),
        .program_done (program_done),
        .timeout      (timeout)
    );

    // Event conditioning; the window bit is sampled alongside so pulses stay aligned.
    always_comb begin
        ev_d = EVENTS_IDLE;
        if (run_s) begin
            ev_d.perf_enable         = 1'b1;
            ev_d.instruction_retired = wb_valid & (wb_instr != 32'h0000_0000);
            ev_d.stall               = pc_stall;
            ev_d.bubble              = id_ex_flush;
            ev_d.forward_ex_to_ex    = fwd_hit(fwd_a_sel, fwd_b_sel, FWD_EX_MEM);
            ev_d.forward_mem_to_ex   = fwd_hit(fwd_a_sel, fwd_b_sel, FWD_MEM_WB);
            ev_d.raw_hazard_detected = load_use_hazard;
            ev_d.branch_instruction  = ex_valid & (ex_is_branch | ex_is_jump);
            ev_d.branch_taken        = ex_valid & (ex_is_branch | ex_is_jump) & ex_taken;
            ev_d.branch_mispredicted = ex_valid & ex_redirect;
        end else begin
            ev_d = EVENTS_IDLE;
        end
    end

    // Output event register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= EVENTS_IDLE;
        end else begin
            ev_q <= ev_d;
        end
    end

    assign perf_enable         = ev_q.perf_enable;
    assign instruction_retired = ev_q.instruction_retired;
    assign stall               = ev_q.stall;
    assign bubble              = ev_q.bubble;
    assign forward_ex_to_ex    = ev_q.forward_ex_to_ex;
    assign forward_mem_to_ex   = ev_q.forward_mem_to_ex;
    assign raw_hazard_detected = ev_q.raw_hazard_detected;
    assign branch_instruction  = ev_q.branch_instruction;
    assign branch_taken        = ev_q.branch_taken;
    assign branch_mispredicted = ev_q.branch_mispredicted;

endmodule

// File: tb/tb_perf_event_tracker.sv
// Scoreboard bench: two trackers (watchdog off, watchdog at 20 cycles) share stimulus;
// a behavioural model pushes expected output vectors that are popped after each edge.
module tb_perf_event_tracker;
    import perf_pkg::*;

    localparam int unsigned ZRUN = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, wb_valid, pc_stall, id_ex_flush, load_use_hazard;
    logic [31:0] wb_instr;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_redirect;

    // Vector bits: 11 pe, 10 retired, 9 stall, 8 bubble, 7 fwd_ex, 6 fwd_mem,
    // 5 raw, 4 br_instr, 3 br_taken, 2 br_misp, 1 done, 0 timeout.
    wire [11:0] out_a;
    wire [11:0] out_w;

    logic [11:0] exp_q_a[$];
    logic [11:0] exp_q_w[$];

    run_state_t  m_st[2];
    int unsigned m_zc[2];
    int unsigned m_cc[2];
    logic        m_to[2];

    int n_total = 0;
    int n_bad   = 0;
    int ir_cnt_a = 0;
    int pe_cnt_w = 0;

    always #5 clk = ~clk;

    perf_event_tracker #(.ZERO_RUN(ZRUN), .MAX_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .wb_valid(wb_valid), .wb_instr(wb_instr),
        .pc_stall(pc_stall), .id_ex_flush(id_ex_flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
        .ex_redirect(ex_redirect),
        .perf_enable(out_a[11]), .instruction_retired(out_a[10]), .stall(out_a[9]),
        .bubble(out_a[8]), .forward_ex_to_ex(out_a[7]), .forward_mem_to_ex(out_a[6]),
        .raw_hazard_detected(out_a[5]), .branch_instruction(out_a[4]),
        .branch_taken(out_a[3]), .branch_mispredicted(out_a[2]),
        .program_done(out_a[1]), .timeout(out_a[0])
    );

    perf_event_tracker #(.ZERO_RUN(ZRUN), .MAX_CYCLES(20)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .wb_valid(wb_valid), .wb_instr(wb_instr),
        .pc_stall(pc_stall), .id_ex_flush(id_ex_flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
        .ex_redirect(ex_redirect),
        .perf_enable(out_w[11]), .instruction_retired(out_w[10]), .stall(out_w[9]),
        .bubble(out_w[8]), .forward_ex_to_ex(out_w[7]), .forward_mem_to_ex(out_w[6]),
        .raw_hazard_detected(out_w[5]), .branch_instruction(out_w[4]),
        .branch_taken(out_w[3]), .branch_mispredicted(out_w[2]),
        .program_done(out_w[1]), .timeout(out_w[0])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned max_of(input int m);
        return (m == 0) ? 0 : 20;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = IDLE;
            m_zc[m] = 0;
            m_cc[m] = 0;
            m_to[m] = 1'b0;
        end
    endtask

    task automatic model_step(input int m, output logic [11:0] e);
        logic run;
        logic wd;
        run   = (m_st[m] == RUN);
        e     = 12'h000;
        e[11] = run;
        e[10] = run & wb_valid & (wb_instr != 32'h0);
        e[9]  = run & pc_stall;
        e[8]  = run & id_ex_flush;
        e[7]  = run & ((fwd_a_sel == 2'b01) || (fwd_b_sel == 2'b01));
        e[6]  = run & ((fwd_a_sel == 2'b10) || (fwd_b_sel == 2'b10));
        e[5]  = run & load_use_hazard;
        e[4]  = run & ex_valid & (ex_is_branch | ex_is_jump);
        e[3]  = run & ex_valid & (ex_is_branch | ex_is_jump) & ex_taken;
        e[2]  = run & ex_valid & ex_redirect;
        if (m_st[m] == IDLE) begin
            if (start) begin
                m_st[m] = RUN;
                m_zc[m] = 0;
                m_cc[m] = 0;
            end
        end else if (m_st[m] == RUN) begin
            if (wb_valid && wb_instr == 32'h0) begin
                if (m_zc[m] < ZRUN) m_zc[m]++;
            end else if (wb_valid) begin
                m_zc[m] = 0;
            end
            wd = (max_of(m) != 0) && (m_cc[m] == max_of(m) - 1);
            if (wd) begin
                m_st[m] = DONE;
                m_to[m] = 1'b1;
            end else if (m_zc[m] == ZRUN) begin
                m_st[m] = DONE;
            end
            m_cc[m]++;
        end
        e[1] = (m_st[m] == DONE);
        e[0] = m_to[m];
    endtask

    task automatic clear_inputs();
        start = 1'b0; wb_valid = 1'b0; wb_instr = 32'h0; pc_stall = 1'b0;
        id_ex_flush = 1'b0; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; load_use_hazard = 1'b0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_redirect = 1'b0;
    endtask

    task automatic step();
        logic [11:0] e;
        model_step(0, e);
        exp_q_a.push_back(e);
        model_step(1, e);
        exp_q_w.push_back(e);
        @(posedge clk);
        #1;
        check_eq("vec_a", 32'(out_a), 32'(exp_q_a.pop_front()));
        check_eq("vec_w", 32'(out_w), 32'(exp_q_w.pop_front()));
        ir_cnt_a += int'(out_a[10]);
        pe_cnt_w += int'(out_w[11]);
    endtask

    task automatic retire(input logic [31:0] instr);
        wb_valid = 1'b1;
        wb_instr = instr;
        step();
        clear_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_a", 32'(out_a), 32'd0);
        check_eq("async_rst_w", 32'(out_w), 32'd0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_a", 32'(out_a), 32'd0);
        check_eq("reset_w", 32'(out_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Events while IDLE stay suppressed.
        pc_stall = 1'b1; fwd_a_sel = 2'b01; ex_valid = 1'b1; ex_is_branch = 1'b1;
        wb_valid = 1'b1; wb_instr = 32'h0000_0013;
        step();
        clear_inputs();
        check_eq("idle_ev", 32'(out_a[11:2]), 32'd0);

        // Start, five non-zero retirements with assorted events, then ten zeros.
        start = 1'b1;
        step();
        clear_inputs();
        ir_cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1;
            wb_instr = 32'h0010_0093 + 32'(i);
            case (i)
                0: begin fwd_a_sel = 2'b01; fwd_b_sel = 2'b10; end
                1: begin fwd_a_sel = 2'b11; fwd_b_sel = 2'b11; pc_stall = 1'b1;
                         id_ex_flush = 1'b1; load_use_hazard = 1'b1; end
                2: begin ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1;
                         ex_redirect = 1'b1; end
                3: begin ex_is_branch = 1'b1; ex_is_jump = 1'b1; ex_taken = 1'b1;
                         ex_redirect = 1'b1; end
                default: begin ex_valid = 1'b1; ex_is_jump = 1'b1; end
            endcase
            step();
            clear_inputs();
            case (i)
                0: check_eq("fwd_both", 32'(out_a[7:6]), 32'd3);
                1: begin
                    check_eq("fwd_11_none", 32'(out_a[7:6]), 32'd0);
                    check_eq("stall_bub_raw", 32'({out_a[9], out_a[8], out_a[5]}), 32'd7);
                end
                2: check_eq("br_all", 32'(out_a[4:2]), 32'd7);
                3: check_eq("br_exv0", 32'(out_a[4:2]), 32'd0);
                default: check_eq("jmp_nt", 32'(out_a[4:2]), 32'd4);
            endcase
        end
        for (int i = 0; i < 10; i++) retire(32'h0);
        check_eq("pe_last_zero", 32'(out_a[11]), 32'd1);
        step();
        check_eq("pe_fall", 32'(out_a[11]), 32'd0);
        check_eq("retired_a", 32'(ir_cnt_a), 32'd5);
        check_eq("done_a", 32'(out_a[1:0]), 32'd2);
        start = 1'b1;
        step();
        clear_inputs();
        check_eq("start_in_done", 32'({out_a[11], out_a[1:0]}), 32'd2);

        // Reset in the middle of RUN, then no window without a fresh start.
        do_reset();
        start = 1'b1;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) retire(32'h0000_0033);
        check_eq("mid_run_pe", 32'(out_a[11]), 32'd1);
        do_reset();
        for (int i = 0; i < 2; i++) retire(32'h0000_0033);
        check_eq("no_start_pe", 32'(out_a[11]), 32'd0);

        // Nine zeros, one non-zero, ten zeros: only the last zero closes the window.
        start = 1'b1;
        step();
        clear_inputs();
        ir_cnt_a = 0;
        for (int i = 0; i < 9; i++) retire(32'h0);
        retire(32'h0000_0013);
        for (int i = 0; i < 9; i++) retire(32'h0);
        check_eq("b_not_done", 32'(out_a[1]), 32'd0);
        retire(32'h0);
        check_eq("b_done", 32'(out_a[1:0]), 32'd2);
        check_eq("b_retired", 32'(ir_cnt_a), 32'd1);
        check_eq("b_wd_collide", 32'(out_w[1:0]), 32'd3);

        // Watchdog: no zeros, window must close after exactly 20 RUN cycles.
        do_reset();
        start = 1'b1;
        step();
        clear_inputs();
        pe_cnt_w = 0;
        for (int i = 0; i < 25; i++) begin
            pc_stall = 1'b1;
            fwd_a_sel = 2'b01;
            retire(32'h0000_0093);
        end
        check_eq("wd_pe_cycles", 32'(pe_cnt_w), 32'd20);
        check_eq("wd_timeout", 32'(out_w[1:0]), 32'd3);
        check_eq("wd_events_off", 32'(out_w[11:2]), 32'd0);
        check_eq("nowd_running", 32'({out_a[11], out_a[1:0]}), 32'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
